freq_edge_counter: RTL
======================

Name: freq_edge_counter

Overview:
- Front end of the frequency counter: synchronises an asynchronous input signal and counts its rising edges over a fixed gate window of UPDATE_PERIOD clocks.
- At each window end it converts the count to two BCD digits by sequential subtract-by-ten.
- Presents the digits with a one-cycle load strobe to the downstream two-digit seven-segment driver (ten_count/unit_count/load).

Parameters:
- UPDATE_PERIOD, 1200, gate window length in clk cycles; legal range 16 to 2^24-1.
- EDGE_W, 8, edge counter width; the counter saturates at 2^EDGE_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- signal  in  1  asynchronous input whose frequency is measured
- ten_count  out  4  BCD tens digit of the last completed window
- unit_count  out  4  BCD units digit of the last completed window
- load  out  1  one-cycle strobe: digits valid, consumer latches them
- overflow  out  1  last completed window counted more than 99 edges

Behaviour:
- Reset: clk and reset as already decided (reset synchronous, active-high; clock clk).
  - ten_count=0, unit_count=0, load=0, overflow=0.
  - Window counter=0, edge counter=0, state=COUNT, synchroniser flops=0.
- Input path: 2-flop synchroniser, then a previous-sample flop. rise = sync & ~prev. A level change on signal produces rise no later than 3 clk cycles after it arrives.
- Window counter:
  - Runs 0..UPDATE_PERIOD-1 continuously, independent of state; wraps to 0.
  - The window-end cycle T is the cycle in which window counter == UPDATE_PERIOD-1.
- Edge counter:
  - Increments on rise and saturates at all-ones.
  - In cycle T, snapshot = edge_counter + rise (saturating), so an edge in cycle T belongs to the old window. The edge counter then clears to 0.
  - Counting continues during conversion; no edges are lost between windows.
- Clamp: if snapshot > 99, the conversion register is loaded with 99 and overflow_next=1; otherwise it is loaded with the snapshot and overflow_next=0.
- FSM states: COUNT, TENS, UNITS.
  - COUNT: in cycle T, load the conversion register, clear the tens accumulator, go to TENS.
  - TENS: if conv >= 10 then conv -= 10, tens += 1, stay in TENS; else go to UNITS.
  - UNITS: register ten_count <= tens, unit_count <= conv[3:0], overflow <= overflow_next, load <= 1. Go to COUNT.
- Outputs:
  - All outputs are registered. load is high for exactly one cycle, coincident with the new digit and overflow values.
  - Digits hold their values between strobes.
- Latency: for clamped value N with t = N/10, load is high in cycle T+t+3. The worst case (N=99) is cycle T+12.
  - UPDATE_PERIOD >= 16 guarantees conversion finishes before the next T.
  - A window end arriving while not in COUNT cannot occur for legal parameters; the RTL asserts this in simulation.
- A zero-edge window still produces load with digits 0,0.
- Reset mid-conversion: return to COUNT immediately, no load pulse is issued, and all outputs are at reset values.
- Signal held at constant 1 through reset: prev and sync reset to 0, so the first post-reset sample of 1 counts as one edge. This is accepted behaviour.

Decomposition:
- freq_counter_pkg:
  - State enum (COUNT, TENS, UNITS).
  - DISPLAY_MAX=99 and BCD_RADIX=10.
  - Shared BCD digit type (4 bits) used by this block and the display driver.
- One sub-module: edge_sync_detect (2-flop synchroniser + rising-edge pulse).

Test Plan:
- Reset held 5 cycles with signal toggling -> ten_count=0, unit_count=0, load=0, overflow=0 throughout.
- UPDATE_PERIOD=1200, square wave period 20 clk -> each window reports ten=6, unit=0, overflow=0. load is high for 1 cycle, exactly every 1200 cycles, at T+9.
- Signal held low for a full window -> load pulses with ten=0, unit=0, overflow=0, at T+3.
- Square wave period 8 clk (150 edges) -> ten=9, unit=9, overflow=1, load at T+12. The next window at period 20 reports 6,0 with overflow=0.
- Single rise placed in cycle T, other rises placed in cycle T+1 -> the rise in T is counted in the old window and the rise in T+1 in the new one. Totals match the number of edges injected per window exactly.
- Reset asserted in TENS (period-20 stimulus, cycle T+4) -> no load that window, digits=0. After release, the next full window reports 6,0.

Source files
------------

// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the frequency counter front end and display driver.
package freq_counter_pkg;

  typedef enum logic [1:0] {
    COUNT,
    TENS,
    UNITS
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned DISPLAY_MAX = 99;
  localparam int unsigned BCD_RADIX   = 10;

endpackage

// File: rtl/freq_edge_counter_sync.sv
// Two-flop synchroniser for an asynchronous input, followed by a rising-edge pulse.
module edge_sync_detect (
  input  logic clk,
  input  logic reset,
  input  logic signal,
  output logic rise
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= signal;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/freq_edge_counter.sv
// Counts synchronised rising edges over a fixed gate window and converts the
// count to two BCD digits by repeated subtraction, strobing load when done.
module freq_edge_counter
  import freq_counter_pkg::*;
#(
  parameter int unsigned UPDATE_PERIOD = 1200,
  parameter int unsigned EDGE_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic signal,
  output bcd_t ten_count,
  output bcd_t unit_count,
  output logic load,
  output logic overflow
);

  localparam int unsigned WIN_W = $clog2(UPDATE_PERIOD);

  logic             rise;
  logic [WIN_W-1:0] win_cnt;
  logic             win_end;
  logic [EDGE_W-1:0] edge_cnt, edge_inc;
  logic             over;
  logic [6:0]       clamped;

  state_t     state, state_n;
  logic [6:0] conv, conv_n;
  bcd_t       tens, tens_n;
  logic       ovf_pend, ovf_pend_n;
  bcd_t       ten_n, unit_n;
  logic       ovf_n, load_n;

  edge_sync_detect u_sync (
    .clk    (clk),
    .reset  (reset),
    .signal (signal),
    .rise   (rise)
  );

  assign win_end = (win_cnt == WIN_W'(UPDATE_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || win_end) win_cnt <= '0;
    else                  win_cnt <= win_cnt + WIN_W'(1);
  end

  // edge_inc doubles as the window snapshot: a rise in the window-end cycle
  // still belongs to the closing window.
  always_comb begin
    edge_inc = edge_cnt;
    if (rise && (edge_cnt != '1)) edge_inc = edge_cnt + EDGE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || win_end) edge_cnt <= '0;
    else                  edge_cnt <= edge_inc;
  end

  assign over    = (32'(edge_inc) > DISPLAY_MAX);
  assign clamped = over ? 7'(DISPLAY_MAX) : 7'(edge_inc);

  always_comb begin
    state_n    = state;
    conv_n     = conv;
    tens_n     = tens;
    ovf_pend_n = ovf_pend;
    ten_n      = ten_count;
    unit_n     = unit_count;
    ovf_n      = overflow;
    load_n     = 1'b0;
    case (state)
      COUNT: begin
        if (win_end) begin
          conv_n     = clamped;
          ovf_pend_n = over;
          tens_n     = '0;
          state_n    = TENS;
        end
      end
      TENS: begin
        if (conv >= 7'(BCD_RADIX)) begin
          conv_n = conv - 7'(BCD_RADIX);
          tens_n = tens + 4'd1;
        end else begin
          state_n = UNITS;
        end
      end
      UNITS: begin
        ten_n   = tens;
        unit_n  = conv[3:0];
        ovf_n   = ovf_pend;
        load_n  = 1'b1;
        state_n = COUNT;
      end
      default: state_n = COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COUNT;
      conv       <= '0;
      tens       <= '0;
      ovf_pend   <= 1'b0;
      ten_count  <= '0;
      unit_count <= '0;
      overflow   <= 1'b0;
      load       <= 1'b0;
    end else begin
      state      <= state_n;
      conv       <= conv_n;
      tens       <= tens_n;
      ovf_pend   <= ovf_pend_n;
      ten_count  <= ten_n;
      unit_count <= unit_n;
      overflow   <= ovf_n;
      load       <= load_n;
    end
  end

  a_window_in_count: assert property (@(posedge clk) disable iff (reset)
    win_end |-> (state == COUNT));

endmodule
